branch_pc_sequencer: RTL and testbench

// Per-thread program counter sequencer; consumer of branch-detector results (jump/destination/cancel).

---
 rtl/branch_pc_sequencer_if.sv | 44 ++++
 rtl/branch_pc_sequencer.sv | 77 +++++++
 tb/tb_branch_pc_sequencer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/branch_pc_sequencer_if.sv
// Bus between the branch detector / fetch control and the per-thread PC sequencer.
// Stats counter signals exist only when BRANCH_PC_STATS_EN is defined.
interface branch_pc_sequencer_if #(
  parameter int PC_WIDTH           = 10,
  parameter int THREAD_COUNT       = 8,
  parameter int THREAD_COUNT_WIDTH = 3,
  parameter int COUNT_WIDTH        = 16
);
  logic [THREAD_COUNT-1:0]       thread_enable;
  logic                          jump;
  logic [PC_WIDTH-1:0]           destination;
  logic                          cancel;
  logic                          pc_wren;
  logic [THREAD_COUNT_WIDTH-1:0] pc_wthread;
  logic [PC_WIDTH-1:0]           pc_wdata;
  logic [PC_WIDTH-1:0]           pc;
  logic [THREAD_COUNT_WIDTH-1:0] pc_thread;
  logic                          pc_valid;
  logic                          alu_cancel;
`ifdef BRANCH_PC_STATS_EN
  logic [COUNT_WIDTH-1:0]        taken_count;
  logic [COUNT_WIDTH-1:0]        cancel_count;

  modport master (
    output thread_enable, jump, destination, cancel, pc_wren, pc_wthread, pc_wdata,
    input  pc, pc_thread, pc_valid, alu_cancel, taken_count, cancel_count
  );

  modport slave (
    input  thread_enable, jump, destination, cancel, pc_wren, pc_wthread, pc_wdata,
    output pc, pc_thread, pc_valid, alu_cancel, taken_count, cancel_count
  );
`else
  modport master (
    output thread_enable, jump, destination, cancel, pc_wren, pc_wthread, pc_wdata,
    input  pc, pc_thread, pc_valid, alu_cancel
  );

  modport slave (
    input  thread_enable, jump, destination, cancel, pc_wren, pc_wthread, pc_wdata,
    output pc, pc_thread, pc_valid, alu_cancel
  );
`endif
endinterface

// File: rtl/branch_pc_sequencer.sv
// Round-robin per-thread PC sequencer for the barrel pipeline fetch stage.
// Optional saturating jump/cancel statistics enabled by defining BRANCH_PC_STATS_EN.
module branch_pc_sequencer #(
  parameter int                  PC_WIDTH           = 10,
  parameter int                  THREAD_COUNT       = 8,
  parameter int                  THREAD_COUNT_WIDTH = 3,
  parameter logic [PC_WIDTH-1:0] START_PC           = '0,
  parameter int                  COUNT_WIDTH        = 16
) (
  input logic                  clock,
  input logic                  reset_n,
  branch_pc_sequencer_if.slave bus
);

  localparam logic [THREAD_COUNT_WIDTH-1:0] LAST_SLOT  = THREAD_COUNT_WIDTH'(THREAD_COUNT - 1);
  localparam logic [THREAD_COUNT_WIDTH:0]   SLOT_LIMIT = (THREAD_COUNT_WIDTH + 1)'(THREAD_COUNT);

  logic [THREAD_COUNT_WIDTH-1:0] slot;
  logic [PC_WIDTH-1:0]           stored_pc [THREAD_COUNT];
  logic                          slot_enabled;
  logic [PC_WIDTH-1:0]           issue_pc;
  logic                          write_in_range;

  // A frozen thread ignores jump, so its issue is simply its stored PC.
  always_comb begin
    slot_enabled   = bus.thread_enable[slot];
    issue_pc       = stored_pc[slot];
    write_in_range = ({1'b0, bus.pc_wthread} < SLOT_LIMIT);
    if (slot_enabled && bus.jump) begin
      issue_pc = bus.destination;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      slot <= '0;
      for (int i = 0; i < THREAD_COUNT; i++) begin
        stored_pc[i] <= START_PC;
      end
      bus.pc         <= '0;
      bus.pc_thread  <= '0;
      bus.pc_valid   <= 1'b0;
      bus.alu_cancel <= 1'b0;
    end else begin
      slot <= (slot == LAST_SLOT) ? '0 : slot + THREAD_COUNT_WIDTH'(1);
      if (slot_enabled) begin
        stored_pc[slot] <= issue_pc + PC_WIDTH'(1);
      end
      // Overwrite comes last so it wins a same-slot collision with the writeback.
      if (bus.pc_wren && write_in_range) begin
        stored_pc[bus.pc_wthread] <= bus.pc_wdata;
      end
      bus.pc         <= issue_pc;
      bus.pc_thread  <= slot;
      bus.pc_valid   <= slot_enabled;
      bus.alu_cancel <= bus.cancel & slot_enabled;
    end
  end

`ifdef BRANCH_PC_STATS_EN
  // Counters saturate at all-ones and clear only on reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      bus.taken_count  <= '0;
      bus.cancel_count <= '0;
    end else begin
      if (slot_enabled && bus.jump && (bus.taken_count != '1)) begin
        bus.taken_count <= bus.taken_count + COUNT_WIDTH'(1);
      end
      if (slot_enabled && bus.cancel && (bus.cancel_count != '1)) begin
        bus.cancel_count <= bus.cancel_count + COUNT_WIDTH'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_pc_sequencer.sv
// Self-checking bench for branch_pc_sequencer against a per-thread PC table model.
// Build with BRANCH_PC_STATS_EN defined to also exercise the saturating counters.
module tb_branch_pc_sequencer;
  localparam int PW = 10;
  localparam int TC = 8;
  localparam int TW = 3;
  localparam int CW = 4;

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  branch_pc_sequencer_if #(.PC_WIDTH(PW), .THREAD_COUNT(TC), .THREAD_COUNT_WIDTH(TW),
                           .COUNT_WIDTH(CW)) bus ();

  branch_pc_sequencer #(.PC_WIDTH(PW), .THREAD_COUNT(TC), .THREAD_COUNT_WIDTH(TW),
                        .START_PC('0), .COUNT_WIDTH(CW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int            n_compared = 0;
  int            n_mismatched = 0;
  logic [PW-1:0] model_pc [TC];
  int            mslot;
  logic [14:0]   exp_out;

  function automatic logic [14:0] observed();
    return {bus.pc, bus.pc_thread, bus.pc_valid, bus.alu_cancel};
  endfunction

  // Drive one slot's inputs, predict that slot's registered outputs, advance one clock.
  task automatic applyStimulus(input logic [TC-1:0] en, input logic j, input logic [PW-1:0] dest,
                               input logic c, input logic wr, input logic [TW-1:0] wt,
                               input logic [PW-1:0] wd);
    logic          e;
    logic [PW-1:0] issue;
    bus.thread_enable = en;
    bus.jump          = j;
    bus.destination   = dest;
    bus.cancel        = c;
    bus.pc_wren       = wr;
    bus.pc_wthread    = wt;
    bus.pc_wdata      = wd;
    e       = en[mslot];
    issue   = (e && j) ? dest : model_pc[mslot];
    exp_out = {issue, TW'(mslot), e, c & e};
    if (e) model_pc[mslot] = issue + PW'(1);
    if (wr) model_pc[wt] = wd;
    mslot = (mslot + 1) % TC;
    @(posedge clock);
    #1;
  endtask

  task automatic advance_to(input int target);
    while (mslot != target) applyStimulus('1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.thread_enable = '1;
    bus.jump = 1'b1;
    bus.destination = PW'($urandom);
    bus.cancel = 1'b1;
    bus.pc_wren = 1'b0;
    bus.pc_wthread = '0;
    bus.pc_wdata = '0;
    repeat (2) @(posedge clock);
    #1;
    n_compared++;
    if (observed() !== 15'h0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_outputs: got %h want %h", observed(), 15'h0);
    end
    reset_n = 1'b1;
    for (int i = 0; i < TC; i++) model_pc[i] = '0;
    mslot = 0;
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 24; i++) begin
      applyStimulus('1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
      n_compared++;
      if (observed() !== {PW'(i / 8), TW'(i % 8), 1'b1, 1'b0}) begin
        n_mismatched++;
        $display("[TB] FAIL sequential_%0d: got %h want %h", i, observed(),
                 {PW'(i / 8), TW'(i % 8), 1'b1, 1'b0});
      end
    end
  endtask

  task automatic test_jump();
    advance_to(3);
    applyStimulus('1, 1'b1, 10'h155, 1'b0, 1'b0, '0, '0);
    n_compared++;
    if (observed() !== {10'h155, 3'd3, 1'b1, 1'b0}) begin
      n_mismatched++;
      $display("[TB] FAIL jump_issue: got %h want %h", observed(), {10'h155, 3'd3, 1'b1, 1'b0});
    end
    advance_to(3);
    applyStimulus('1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    n_compared++;
    if (bus.pc !== 10'h156) begin
      n_mismatched++;
      $display("[TB] FAIL jump_next: got %h want %h", bus.pc, 10'h156);
    end
  endtask

  task automatic test_wrap();
    advance_to(1);
    applyStimulus('1, 1'b0, '0, 1'b0, 1'b1, 3'd5, 10'h3FF);
    advance_to(5);
    applyStimulus('1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    n_compared++;
    if (bus.pc !== 10'h3FF) begin
      n_mismatched++;
      $display("[TB] FAIL wrap_issue: got %h want %h", bus.pc, 10'h3FF);
    end
    advance_to(5);
    applyStimulus('1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    n_compared++;
    if (bus.pc !== 10'h000) begin
      n_mismatched++;
      $display("[TB] FAIL wrap_next: got %h want %h", bus.pc, 10'h000);
    end
  endtask

  task automatic test_disabled();
    logic [PW-1:0] prior;
    advance_to(2);
    prior = model_pc[2];
    applyStimulus(8'hFB, 1'b1, 10'h2AA, 1'b1, 1'b0, '0, '0);
    n_compared++;
    if (observed() !== {prior, 3'd2, 1'b0, 1'b0}) begin
      n_mismatched++;
      $display("[TB] FAIL disabled_slot: got %h want %h", observed(), {prior, 3'd2, 1'b0, 1'b0});
    end
    advance_to(2);
    applyStimulus('1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    n_compared++;
    if (bus.pc !== prior) begin
      n_mismatched++;
      $display("[TB] FAIL disabled_frozen: got %h want %h", bus.pc, prior);
    end
  endtask

  task automatic test_cancel_no_jump();
    advance_to(4);
    applyStimulus('1, 1'b0, '0, 1'b1, 1'b0, '0, '0);
    n_compared++;
    if (bus.alu_cancel !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL cancel_no_jump: got %b want %b", bus.alu_cancel, 1'b1);
    end
  endtask

  task automatic test_collision();
    advance_to(6);
    applyStimulus('1, 1'b1, 10'h100, 1'b0, 1'b1, 3'd6, 10'h040);
    n_compared++;
    if (bus.pc !== 10'h100) begin
      n_mismatched++;
      $display("[TB] FAIL collision_issue: got %h want %h", bus.pc, 10'h100);
    end
    advance_to(6);
    applyStimulus('1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    n_compared++;
    if (bus.pc !== 10'h040) begin
      n_mismatched++;
      $display("[TB] FAIL collision_next: got %h want %h", bus.pc, 10'h040);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      applyStimulus(TC'($urandom), 1'($urandom_range(0, 1)), PW'($urandom),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                    TW'($urandom), PW'($urandom));
      n_compared++;
      if (observed() !== exp_out) begin
        n_mismatched++;
        $display("[TB] FAIL random_%0d: got %h want %h", i, observed(), exp_out);
      end
    end
  endtask

  task automatic test_midrun_reset();
    test_reset();
    applyStimulus('1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    n_compared++;
    if (observed() !== {10'h000, 3'd0, 1'b1, 1'b0}) begin
      n_mismatched++;
      $display("[TB] FAIL midrun_reset: got %h want %h", observed(), {10'h000, 3'd0, 1'b1, 1'b0});
    end
  endtask

`ifdef BRANCH_PC_STATS_EN
  task automatic test_stats();
    test_reset();
    for (int i = 0; i < 20; i++) applyStimulus('1, 1'b1, PW'($urandom), 1'b1, 1'b0, '0, '0);
    n_compared++;
    if ({bus.taken_count, bus.cancel_count} !== {4'hF, 4'hF}) begin
      n_mismatched++;
      $display("[TB] FAIL stats_saturate: got %h want %h", {bus.taken_count, bus.cancel_count}, 8'hFF);
    end
    test_reset();
    n_compared++;
    if ({bus.taken_count, bus.cancel_count} !== 8'h00) begin
      n_mismatched++;
      $display("[TB] FAIL stats_reset: got %h want %h", {bus.taken_count, bus.cancel_count}, 8'h00);
    end
  endtask
`endif

  initial begin
    $display("[TB] start");
    test_reset();
    test_sequential();
    test_jump();
    test_wrap();
    test_disabled();
    test_cancel_no_jump();
    test_collision();
    test_random();
    test_midrun_reset();
`ifdef BRANCH_PC_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
